// File: rtl/seg_pkg.sv
// Shared display definitions: segment encoding, display constants and the converter FSM states.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off; A..F decode as hex letters.
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock for WIDTH clocks.
module bcd_double_dabble #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned SrW  = 4 * DIGITS + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [SrW-1:0]  sr_q, sr_d, adj;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;

  // done marks the cycle of the final step; bcd holds the result from the next cycle on.
  assign done = run_q && (cnt_q == CntW'(WIDTH - 1));
  assign bcd  = sr_q[SrW-1 -: 4*DIGITS];

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[WIDTH+4*i +: 4] >= 4'd5) begin
        adj[WIDTH+4*i +: 4] = sr_q[WIDTH+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      sr_d  = SrW'(bin);
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      sr_d  = {adj[SrW-2:0], 1'b0};
      cnt_d = cnt_q + CntW'(1);
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Calculator display back-end: value handshake, BCD conversion, multiplexed 7-segment scan.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned VALUE_W    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic [7:0]            sg_out,
  output logic                  busy
);

  localparam int unsigned TICKS          = CLK_HZ / REFRESH_HZ;
  localparam int unsigned TickW          = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int unsigned IdxW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam longint unsigned MAX_DISP   = pow10(NUM_DIGITS) - 64'd1;

  state_t state_q, state_d;
  logic   ovf_q, ovf_d;
  logic   start;
  logic   conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;

  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic                       disp_ovf_q;

  logic [TickW-1:0]      tick_q;
  logic [IdxW-1:0]       idx_q;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [7:0]            sg_nxt;

  assign value_ready = (state_q == IDLE);
  assign busy        = ~value_ready;

  bcd_double_dabble #(
    .WIDTH  (VALUE_W),
    .DIGITS (NUM_DIGITS)
  ) u_dd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value_in),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (value_valid) begin
          if (64'(value_in) > MAX_DISP) begin
            ovf_d   = 1'b1;
            state_d = LOAD;
          end else begin
            ovf_d   = 1'b0;
            start   = 1'b1;
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        if (conv_done) begin
          state_d = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // The display only changes in LOAD, so the old value stays up during conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
    end else if (state_q == LOAD) begin
      disp_ovf_q <= ovf_q;
      disp_q     <= ovf_q ? '0 : conv_bcd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else if (tick_q == TickW'(TICKS - 1)) begin
      tick_q <= '0;
      idx_q  <= (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end else begin
      tick_q <= tick_q + TickW'(1);
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic zero_run;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_run = zero_run & (disp_q[i] == 4'd0);
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    an_nxt = ~(NUM_DIGITS'(1) << idx_q);
    if (disp_ovf_q) begin
      sg_nxt = SEG_DASH;
    end else if (blank[idx_q]) begin
      sg_nxt = SEG_BLANK;
    end else begin
      sg_nxt = seg_encode(disp_q[idx_q]);
    end
    if (dp_mask[idx_q]) begin
      sg_nxt[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_out <= '1;
      sg_out <= SEG_BLANK;
    end else begin
      an_out <= an_nxt;
      sg_out <= sg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (TICKS=10, three digits, 10-bit values).
module tb_seg_scan_driver;

  logic       clk;
  logic       reset;
  logic [9:0] value_in;
  logic       value_valid;
  logic       value_ready;
  logic [2:0] dp_mask;
  logic [2:0] an_out;
  logic [7:0] sg_out;
  logic       busy;

  int vectors;
  int miscompares;

  seg_scan_driver #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (100),
    .NUM_DIGITS (3),
    .VALUE_W    (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .dp_mask     (dp_mask),
    .an_out      (an_out),
    .sg_out      (sg_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance until digit d is being driven; sampled 1 time unit after the edge.
  task automatic wait_digit(input int d, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (an_out === ~(3'b001 << d)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (!value_ready && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Called at a sample point with value_ready high; returns 1 unit after the transfer edge.
  task automatic send(input logic [9:0] v);
    value_in    = v;
    value_valid = 1'b1;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [2:0] exp_an;
    logic [7:0] exp_sg;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (an_out !== 3'b111 || sg_out !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_async: an_out=%b sg_out=%h expected an_out=111 sg_out=ff",
               an_out, sg_out);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      exp_an = (i < 10) ? 3'b110 : (i < 20) ? 3'b101 : 3'b011;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      exp_sg = (i < 10) ? 8'hC0 : 8'hFF;
`else
      exp_sg = 8'hC0;
`endif
      vectors++;
      if (an_out !== exp_an || sg_out !== exp_sg) begin
        miscompares++;
        $display("FAIL scan_after_reset cycle %0d: an_out=%b sg_out=%h expected an_out=%b sg_out=%h",
                 i, an_out, sg_out, exp_an, exp_sg);
      end
    end
  endtask

  task automatic test_convert;
    int n;
    bit found;
    logic [7:0] exp [3];
    exp = '{8'hB0, 8'hA4, 8'hF9};
    send(10'd123);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_123: busy=%b expected 1", busy);
    end
    count_busy(n);
    vectors++;
    if (n != 11) begin
      miscompares++;
      $display("FAIL latency_123: ready low %0d cycles expected 11", n);
    end
    for (int d = 0; d < 3; d++) begin
      wait_digit(d, found);
      vectors++;
      if (!found || sg_out !== exp[d]) begin
        miscompares++;
        $display("FAIL digit%0d_123: sg_out=%h found=%0d expected %h", d, sg_out, found, exp[d]);
      end
    end
  endtask

  task automatic test_overflow;
    int n;
    bit found;
    send(10'd1000);
    count_busy(n);
    vectors++;
    if (n != 1) begin
      miscompares++;
      $display("FAIL latency_ovf: ready low %0d cycles expected 1", n);
    end
    for (int d = 0; d < 3; d++) begin
      wait_digit(d, found);
      vectors++;
      if (!found || sg_out !== 8'hBF) begin
        miscompares++;
        $display("FAIL dash%0d: sg_out=%h found=%0d expected bf", d, sg_out, found);
      end
    end
    dp_mask = 3'b100;
    wait_digit(2, found);
    vectors++;
    if (!found || sg_out !== 8'h3F) begin
      miscompares++;
      $display("FAIL dash2_dp: sg_out=%h found=%0d expected 3f", sg_out, found);
    end
    wait_digit(0, found);
    vectors++;
    if (!found || sg_out !== 8'hBF) begin
      miscompares++;
      $display("FAIL dash0_nodp: sg_out=%h found=%0d expected bf", sg_out, found);
    end
    dp_mask = 3'b000;
  endtask

  task automatic test_back_to_back;
    int n;
    bit found;
    logic [7:0] exp [3];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    exp = '{8'hF8, 8'hFF, 8'hFF};
`else
    exp = '{8'hF8, 8'hC0, 8'hC0};
`endif
    send(10'd5);
    value_in    = 10'd7;
    value_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sg_out !== 8'hBF) begin
      miscompares++;
      $display("FAIL persist_during_convert: sg_out=%h expected bf", sg_out);
    end
    count_busy(n);
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL latency_5_held: ready low %0d more cycles expected 8", n);
    end
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    vectors++;
    if (value_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_7: value_ready=%b expected 0 after transfer", value_ready);
    end
    count_busy(n);
    vectors++;
    if (n != 11) begin
      miscompares++;
      $display("FAIL latency_7: ready low %0d cycles expected 11", n);
    end
    for (int d = 0; d < 3; d++) begin
      wait_digit(d, found);
      vectors++;
      if (!found || sg_out !== exp[d]) begin
        miscompares++;
        $display("FAIL digit%0d_007: sg_out=%h found=%0d expected %h", d, sg_out, found, exp[d]);
      end
    end
  endtask

  task automatic test_reset_mid_convert;
    bit found;
    logic [7:0] exp [3];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    exp = '{8'hC0, 8'hFF, 8'hFF};
`else
    exp = '{8'hC0, 8'hC0, 8'hC0};
`endif
    send(10'd999);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (value_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_abort: value_ready=%b busy=%b expected 1 0", value_ready, busy);
    end
    for (int d = 0; d < 3; d++) begin
      wait_digit(d, found);
      vectors++;
      if (!found || sg_out !== exp[d]) begin
        miscompares++;
        $display("FAIL digit%0d_abort: sg_out=%h found=%0d expected %h", d, sg_out, found, exp[d]);
      end
    end
    vectors++;
    if (value_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_abort: value_ready=%b expected 1", value_ready);
    end
  endtask

  task automatic test_blank;
    int n;
    bit found;
    logic [7:0] exp [3];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    exp = '{8'hF8, 8'h7F, 8'hFF};
`else
    exp = '{8'hF8, 8'h40, 8'hC0};
`endif
    dp_mask = 3'b010;
    send(10'd7);
    count_busy(n);
    for (int d = 0; d < 3; d++) begin
      wait_digit(d, found);
      vectors++;
      if (!found || sg_out !== exp[d]) begin
        miscompares++;
        $display("FAIL digit%0d_blank: sg_out=%h found=%0d expected %h", d, sg_out, found, exp[d]);
      end
    end
    dp_mask = 3'b000;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    value_in    = '0;
    value_valid = 1'b0;
    dp_mask     = 3'b000;
    test_reset();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_reset_mid_convert();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Display back-end of the calculator. It accepts an unsigned binary result from the calculator core over a valid/ready handshake and converts it to BCD with a sequential double-dabble. It then time-multiplexes the digits onto the board's common-anode seven-segment display through an_out/sg_out. The block sits directly downstream of the calculator datapath and drives the top-level display pins.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
REFRESH_HZ, 1000, per-digit dwell rate; digit dwell = CLK_HZ/REFRESH_HZ cycles
NUM_DIGITS, 3, number of physical digits (width of an_out)
VALUE_W, 10, width of binary input value

Ports:
clk  input  1  system clock; one clock domain only
reset  input  1  asynchronous, active-high reset
value_in  input  VALUE_W  unsigned result from calculator core
value_valid  input  1  value_in is valid
value_ready  output  1  block can accept a value; high only in IDLE
dp_mask  input  NUM_DIGITS  per-digit decimal point enable; bit0 is the rightmost digit; sampled live
an_out  output  NUM_DIGITS  anode enables, active low, one-hot-low while scanning
sg_out  output  8  segments, active low, bit order {dp,g,f,e,d,c,b,a}
busy  output  1  conversion in progress; equals ~value_ready

Behaviour:
- Reset is asynchronous and active-high. While reset is high: an_out = all ones, sg_out = 8'hFF, state = IDLE, display register = all digits 0, overflow flag = 0, scan index = 0, tick counter = 0.
- Handshake: transfer occurs on a rising edge with value_valid & value_ready. value_valid while busy is ignored; upstream holds value_valid until it sees ready. Nothing is buffered.
- FSM states:
  - IDLE: on transfer, if value_in > 10^NUM_DIGITS-1, set overflow and go to LOAD; else load the shift register and go to CONVERT.
  - CONVERT: one double-dabble step per cycle (add-3 to each BCD nibble >= 5, then shift left 1). Runs for exactly VALUE_W cycles, then goes to LOAD.
  - LOAD: commit BCD nibbles (or overflow) to the display register; return to IDLE.
- Latency: a transfer at edge N gives display register update at edge N+VALUE_W+1 and value_ready high again after that edge. The overflow path updates at edge N+1. The previous display persists during conversion.
- Overflow display: every digit shows a dash, sg_out = 8'hBF (g only); dp still follows dp_mask.
- Scan behaviour:
  - The tick counter runs 0..TICKS-1, with TICKS = CLK_HZ/REFRESH_HZ.
  - On wrap, the scan index increments modulo NUM_DIGITS.
  - an_out and sg_out are registered; the first cycle after reset release drives digit 0.
  - The scan runs independently of the FSM and never stalls.
- Segment codes, hex 0..9 (dp off): C0 F9 A4 B0 99 92 82 F8 80 90. dp_mask[i]=1 clears bit7 for digit i.
- Reset mid-CONVERT aborts conversion; the display returns to zeros and no partial result is committed.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN:
- Defined: zero digits left of the most significant non-zero digit show sg[6:0] = 7'h7F (blank), with dp still per dp_mask. Digit 0 is never blanked. Overflow dashes are never blanked.
- Undefined: all digits show their value, including leading zeros.

Decomposition:
- Package seg_pkg holds:
  - the segment encoding function (4-bit digit to 8-bit active-low code)
  - constants SEG_BLANK=8'hFF and SEG_DASH=8'hBF
  - the FSM state enum (IDLE, CONVERT, LOAD)
- One sub-module: bcd_double_dabble, the sequential converter (start, bin in, done, BCD out). seg_scan_driver keeps the handshake, overflow, display register and scan logic.

Test Plan (CLK_HZ=1000, REFRESH_HZ=100, so TICKS=10; NUM_DIGITS=3, VALUE_W=10):
- Reset asserted mid-cycle -> an_out=3'b111 and sg_out=8'hFF immediately. After release -> an_out=3'b110 and sg_out=8'hC0, with each digit held 10 cycles in order 110, 101, 011.
- Send 123 -> value_ready low for 11 cycles. Then digit0=8'hB0, digit1=8'hA4, digit2=8'hF9.
- Send 1000 -> value_ready low for 1 cycle. Then all three digits show 8'hBF; dp_mask=3'b100 makes digit2 8'h3F.
- Send 5, then hold value_valid with 7 asserted during busy -> 7 is accepted only when value_ready returns. The display ends at digits 8'hF8, 8'hC0, 8'hC0 (macro undefined).
- Send 999, then assert reset 4 cycles into CONVERT -> the display shows 000 after release and value_ready is high.
- SEG_LEADING_ZERO_BLANK_EN defined, send 7 with dp_mask=3'b010 -> digit0=8'hF8, digit1=8'h7F, digit2=8'hFF.
